bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that consumes the quotient or remainder produced by the algorithmic divider. It converts a two's-complement or unsigned word into sign plus packed decimal digits for the display/output stage. The block uses shift-and-add-3 (double dabble), one bit per cycle. Its Start/Done handshake matches the divider's, so the divider's Done can drive Start directly.

---
 rtl/bcd_converter_pkg.sv | 17 +
 rtl/bcd_converter_digit_adj.sv | 11 +
 rtl/bcd_converter.sv | 115 +++++++++++
 tb/tb_bcd_converter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_converter_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_converter_pkg;

    localparam int DIGITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 once doubled.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_converter_digit_adj.sv
// Combinational add-3 correction for one BCD digit of the accumulator.
module bcd_digit_adj
    import bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = add3(digit_in);

endmodule

// File: rtl/bcd_converter.sv
// Binary (signed or unsigned) to sign + packed BCD, one double-dabble step per cycle.
// Start/Done handshake is compatible with the divider's, so Done can feed Start directly.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int tamanyo = 32,
    parameter int DIGITS  = DIGITS_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTa,
    input  logic                  Start,
    input  logic                  Signed_in,
    input  logic [tamanyo-1:0]    Bin,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Neg,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CW = $clog2(tamanyo);
    localparam int AW = 4 * DIGITS;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [tamanyo-1:0]  sh_q, sh_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       acc_adj;
    logic                neg_r_q, neg_r_d;
    logic [AW-1:0]       bcd_q, bcd_d;
    logic                neg_q, neg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                neg_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        neg_r_d = neg_r_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_in  = Signed_in & Bin[tamanyo-1];

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    neg_r_d = neg_in;
                    // Magnitude kept unsigned so the most negative value still fits.
                    sh_d    = neg_in ? (~Bin + tamanyo'(1)) : Bin;
                    acc_d   = '0;
                    cnt_d   = CW'(tamanyo - 1);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                {acc_d, sh_d} = {acc_adj, sh_q} << 1;
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_d   = acc_q;
                neg_d   = neg_r_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            neg_r_q <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            neg_r_q <= neg_r_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign Neg  = neg_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Randomized self-checking bench for bcd_converter against a decimal-arithmetic model.
module tb_bcd_converter;

    logic        CLK;
    logic        RSTa;
    logic        Start;
    logic        Signed_in;
    logic [31:0] Bin;
    logic [39:0] BCD;
    logic        Neg;
    logic        Busy;
    logic        Done;

    int  vectors;
    int  miscompares;
    time t_done;

    bcd_converter #(.tamanyo(32), .DIGITS(10)) dut (
        .CLK       (CLK),
        .RSTa      (RSTa),
        .Start     (Start),
        .Signed_in (Signed_in),
        .Bin       (Bin),
        .BCD       (BCD),
        .Neg       (Neg),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the magnitude by repeated division.
    task automatic model(input logic s, input logic [31:0] b,
                         output logic [39:0] eb, output logic en);
        longint unsigned m;
        en = s & b[31];
        m  = en ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        eb = '0;
        for (int i = 0; i < 10; i++) begin
            eb[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endtask

    // Call one sample (#1) after a rising edge. Returns in the Done cycle.
    task automatic run_conv(input logic s, input logic [31:0] b, input bit hold);
        logic [39:0] eb;
        logic        en;
        logic [39:0] prev;
        int          n;
        int          busy_n;
        bit          stable;
        model(s, b, eb, en);
        prev      = BCD;
        Start     = 1'b1;
        Signed_in = s;
        Bin       = b;
        @(posedge CLK); #1;
        if (!hold) Start = 1'b0;
        Signed_in = 1'($urandom);
        Bin       = $urandom;
        n      = 0;
        busy_n = 0;
        stable = 1'b1;
        while (!Done && n < 100) begin
            if (Busy) busy_n++;
            if (BCD !== prev) stable = 1'b0;
            if (hold) begin
                Bin       = $urandom;
                Signed_in = 1'($urandom);
                if (n == 31) Start = 1'b0;
            end
            @(posedge CLK); #1;
            n++;
        end
        t_done = $time;
        chk("latency", 64'(n), 64'd33);
        chk("busy_cycles", 64'(busy_n), 64'd33);
        chk("busy_low_at_done", 64'(Busy), 64'd0);
        chk("bcd_hold", 64'(stable), 64'd1);
        chk("bcd", 64'(BCD), 64'(eb));
        chk("neg", 64'(Neg), 64'(en));
    endtask

    initial begin
        logic [31:0] r;
        logic        rs;
        time         t1;
        int          done_seen;
        vectors     = 0;
        miscompares = 0;
        RSTa      = 1'b0;
        Start     = 1'b0;
        Signed_in = 1'b0;
        Bin       = '0;
        repeat (3) @(posedge CLK);
        #1;
        RSTa = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_bcd", 64'(BCD), 64'd0);
        chk("rst_neg", 64'(Neg), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);

        run_conv(1'b1, 32'hFFED2979, 1'b0);
        chk("neg1234567", 64'(BCD), 64'h0001234567);
        run_conv(1'b1, 32'h80000000, 1'b0);
        chk("int_min", 64'(BCD), 64'h2147483648);
        run_conv(1'b1, 32'h7FFFFFFF, 1'b0);
        chk("int_max", 64'(BCD), 64'h2147483647);
        run_conv(1'b0, 32'hFFFFFFFF, 1'b0);
        chk("uint_max", 64'(BCD), 64'h4294967295);
        run_conv(1'b0, 32'h00000000, 1'b0);
        run_conv(1'b1, 32'h00000000, 1'b0);
        run_conv(1'b1, 32'hFFFFFFF2, 1'b0);
        chk("div_coc", 64'(BCD), 64'h0000000014);

        // Start held high while Bin wanders: only the E0 sample matters.
        @(posedge CLK); #1;
        run_conv(1'b1, 32'hFFFF0001, 1'b1);
        @(posedge CLK); #1;
        run_conv(1'b0, $urandom, 1'b1);

        // Random mix; every other pair issued back to back from the Done cycle.
        for (int k = 0; k < 30; k++) begin
            r  = $urandom;
            rs = 1'($urandom);
            if (k % 4 == 0) r = {r[31], 31'(r[7:0])};
            if (k % 2 == 0) begin
                @(posedge CLK); #1;
                run_conv(rs, r, 1'b0);
            end else begin
                t1 = t_done;
                run_conv(rs, r, 1'b0);
                chk("b2b_gap", 64'((t_done - t1) / 10), 64'd34);
            end
        end

        // Reset in the middle of a conversion.
        @(posedge CLK); #1;
        Start     = 1'b1;
        Signed_in = 1'b1;
        Bin       = 32'h87654321;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("mid_busy", 64'(Busy), 64'd1);
        @(posedge CLK); #1;
        RSTa = 1'b0;
        #1;
        chk("arst_bcd", 64'(BCD), 64'd0);
        chk("arst_neg", 64'(Neg), 64'd0);
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_done", 64'(Done), 64'd0);
        @(posedge CLK); #1;
        RSTa = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (Done || Busy) done_seen++;
        end
        chk("no_done_after_abort", 64'(done_seen), 64'd0);
        chk("bcd_after_abort", 64'(BCD), 64'd0);

        run_conv(1'b1, 32'hFFFFFF9C, 1'b0);
        chk("recover_neg100", 64'(BCD), 64'h0000000100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
